// File: rtl/msp430_gpio_port_if.sv
// Peripheral-bus view of the MSP430 GPIO port: word address, write data,
// access strobes and the OR-combinable read-back path.
interface msp430_gpio_port_if;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;

    modport master (
        output per_addr,
        output per_din,
        output per_en,
        output per_we,
        input  per_dout
    );

    modport slave (
        input  per_addr,
        input  per_din,
        input  per_en,
        input  per_we,
        output per_dout
    );
endinterface

// File: rtl/msp430_gpio_port.sv
// MSP430 GPIO port: per-pin direction/output/function-select muxing onto the
// io cells, two-flop input synchronisation and edge-triggered interrupt flags.
module msp430_gpio_port #(
    parameter int          WIDTH     = 8,
    parameter logic [13:0] BASE_ADDR = 14'h0010
) (
    input  logic              mclk,
    input  logic              reset_n,
    msp430_gpio_port_if.slave bus,
    input  logic [WIDTH-1:0]  p_din,
    output logic [WIDTH-1:0]  p_dout,
    output logic [WIDTH-1:0]  p_dout_en,
    input  logic [WIDTH-1:0]  alt_dout,
    input  logic [WIDTH-1:0]  alt_dout_en,
    output logic [WIDTH-1:0]  alt_din,
    output logic              irq
);

    localparam logic [2:0] OFF_PIN  = 3'd0;
    localparam logic [2:0] OFF_POUT = 3'd1;
    localparam logic [2:0] OFF_PDIR = 3'd2;
    localparam logic [2:0] OFF_PSEL = 3'd3;
    localparam logic [2:0] OFF_PIES = 3'd4;
    localparam logic [2:0] OFF_PIE  = 3'd5;
    localparam logic [2:0] OFF_PIFG = 3'd6;

    logic             sel;
    logic             wr;
    logic             rd;
    logic [2:0]       offset;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] pout;
    logic [WIDTH-1:0] pdir;
    logic [WIDTH-1:0] psel;
    logic [WIDTH-1:0] pies;
    logic [WIDTH-1:0] pie;
    logic [WIDTH-1:0] pifg;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] pin_edge;
    logic [WIDTH-1:0] pifg_base;
    logic [WIDTH-1:0] rd_data;
    logic             unused_din;

    assign offset = bus.per_addr[2:0];
    assign sel    = bus.per_en && (bus.per_addr[13:3] == BASE_ADDR[13:3]);
    assign wr     = sel && bus.per_we[0];
    assign rd     = sel && (bus.per_we == 2'b00);
    assign wdata  = bus.per_din[WIDTH-1:0];

    // Upper data bits carry nothing for this byte-wide peripheral.
    assign unused_din = ^bus.per_din[15:WIDTH];

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            pout <= '0;
            pdir <= '0;
            psel <= '0;
            pies <= '0;
            pie  <= '0;
        end else if (wr) begin
            case (offset)
                OFF_POUT: pout <= wdata;
                OFF_PDIR: pdir <= wdata;
                OFF_PSEL: psel <= wdata;
                OFF_PIES: pies <= wdata;
                OFF_PIE:  pie  <= wdata;
                default:  ;
            endcase
        end
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= p_din;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Edges come from sync2 vs prev only, so rewriting PIES can never fake one.
    assign rise     = sync2 & ~prev;
    assign fall     = ~sync2 & prev;
    assign pin_edge = (pies & fall) | (~pies & rise);

    assign pifg_base = (wr && offset == OFF_PIFG) ? wdata : pifg;

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            pifg <= '0;
        end else begin
            pifg <= pifg_base | pin_edge;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd) begin
            case (offset)
                OFF_PIN:  rd_data = sync2;
                OFF_POUT: rd_data = pout;
                OFF_PDIR: rd_data = pdir;
                OFF_PSEL: rd_data = psel;
                OFF_PIES: rd_data = pies;
                OFF_PIE:  rd_data = pie;
                OFF_PIFG: rd_data = pifg;
                default:  rd_data = '0;
            endcase
        end
    end

    assign bus.per_dout = {{(16-WIDTH){1'b0}}, rd_data};

    assign p_dout    = (psel & alt_dout)    | (~psel & pout);
    assign p_dout_en = (psel & alt_dout_en) | (~psel & pdir);
    assign alt_din   = sync2;
    assign irq       = |(pifg & pie);

endmodule

// File: tb/tb_msp430_gpio_port.sv
// Self-checking bench for msp430_gpio_port: register reads go through a
// scoreboard queue, pad-side behaviour is checked inline per scenario.
module tb_msp430_gpio_port;

    localparam int          WIDTH = 8;
    localparam logic [13:0] BASE  = 14'h0010;

    typedef struct {
        string       name;
        logic [15:0] value;
    } exp_t;

    logic             mclk = 1'b0;
    logic             reset_n = 1'b0;
    logic [WIDTH-1:0] p_din;
    logic [WIDTH-1:0] p_dout;
    logic [WIDTH-1:0] p_dout_en;
    logic [WIDTH-1:0] alt_dout;
    logic [WIDTH-1:0] alt_dout_en;
    logic [WIDTH-1:0] alt_din;
    logic             irq;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    event rd_sample;

    msp430_gpio_port_if bus_if();

    msp430_gpio_port #(
        .WIDTH    (WIDTH),
        .BASE_ADDR(BASE)
    ) dut (
        .mclk       (mclk),
        .reset_n    (reset_n),
        .bus        (bus_if),
        .p_din      (p_din),
        .p_dout     (p_dout),
        .p_dout_en  (p_dout_en),
        .alt_dout   (alt_dout),
        .alt_dout_en(alt_dout_en),
        .alt_din    (alt_din),
        .irq        (irq)
    );

    always #5 mclk = ~mclk;

    // Scoreboard: each read pushes its expectation, popped when per_dout is sampled.
    always @(rd_sample) begin
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL scoreboard: read with empty queue, per_dout=%h", bus_if.per_dout);
        end else begin
            e = sb_q.pop_front();
            if (bus_if.per_dout !== e.value) begin
                errors++;
                $display("[TB] FAIL %s: per_dout=%h expected %h", e.name, bus_if.per_dout, e.value);
            end
        end
    end

    task automatic bus_write(input logic [2:0] off, input logic [7:0] data);
        @(negedge mclk);
        bus_if.per_addr = {BASE[13:3], off};
        bus_if.per_din  = {8'($urandom), data};
        bus_if.per_we   = 2'b01;
        bus_if.per_en   = 1'b1;
        @(posedge mclk);
        #1;
        bus_if.per_en = 1'b0;
        bus_if.per_we = 2'b00;
    endtask

    task automatic bus_read(input logic [2:0] off, input logic [15:0] value, input string name);
        exp_t e;
        @(negedge mclk);
        bus_if.per_addr = {BASE[13:3], off};
        bus_if.per_we   = 2'b00;
        bus_if.per_en   = 1'b1;
        e.name  = name;
        e.value = value;
        sb_q.push_back(e);
        #2;
        -> rd_sample;
        #1;
        bus_if.per_en = 1'b0;
    endtask

    task automatic test_reset();
        reset_n         = 1'b0;
        alt_dout        = 8'hFF;
        alt_dout_en     = 8'hFF;
        p_din           = 8'h00;
        bus_if.per_addr = 14'h0;
        bus_if.per_din  = 16'h0;
        bus_if.per_we   = 2'b00;
        bus_if.per_en   = 1'b0;
        #12;
        checks++;
        if (p_dout_en !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset p_dout_en: got %h expected 00", p_dout_en);
        end
        checks++;
        if (p_dout !== 8'h00 || irq !== 1'b0 || alt_din !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset outputs: p_dout=%h irq=%b alt_din=%h expected 00/0/00", p_dout, irq, alt_din);
        end
        @(negedge mclk);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus_read(3'(i), 16'h0000, $sformatf("reg%0d after reset", i));
        end
        bus_write(3'd1, 8'h5A);
        @(negedge mclk);
        bus_if.per_addr = 14'h0101;
        bus_if.per_we   = 2'b00;
        bus_if.per_en   = 1'b1;
        #2;
        checks++;
        if (bus_if.per_dout !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL unselected read: per_dout=%h expected 0000", bus_if.per_dout);
        end
        bus_if.per_addr = {BASE[13:3], 3'd1};
        bus_if.per_en   = 1'b0;
        #1;
        checks++;
        if (bus_if.per_dout !== 16'h0000) begin
            errors++;
            $display("[TB] FAIL idle bus: per_dout=%h expected 0000", bus_if.per_dout);
        end
        bus_write(3'd1, 8'h00);
    endtask

    task automatic test_gpio_drive();
        bus_write(3'd2, 8'hA5);
        checks++;
        if (p_dout_en !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL gpio p_dout_en: got %h expected a5", p_dout_en);
        end
        bus_write(3'd1, 8'h0F);
        checks++;
        if (p_dout !== 8'h0F) begin
            errors++;
            $display("[TB] FAIL gpio p_dout: got %h expected 0f", p_dout);
        end
        bus_read(3'd1, 16'h000F, "POUT readback");
        bus_read(3'd2, 16'h00A5, "PDIR readback");
    endtask

    task automatic test_alt_mux();
        alt_dout    = 8'h01;
        alt_dout_en = 8'h03;
        bus_write(3'd2, 8'h00);
        bus_write(3'd3, 8'h03);
        checks++;
        if (p_dout_en !== 8'h03) begin
            errors++;
            $display("[TB] FAIL alt p_dout_en: got %h expected 03", p_dout_en);
        end
        checks++;
        if (p_dout !== 8'h0D) begin
            errors++;
            $display("[TB] FAIL alt p_dout: got %h expected 0d", p_dout);
        end
        bus_write(3'd3, 8'h00);
        checks++;
        if (p_dout_en !== 8'h00 || p_dout !== 8'h0F) begin
            errors++;
            $display("[TB] FAIL gpio restore: p_dout_en=%h p_dout=%h expected 00/0f", p_dout_en, p_dout);
        end
    endtask

    task automatic test_rise_irq();
        bus_write(3'd5, 8'h01);
        bus_write(3'd4, 8'h00);
        @(negedge mclk);
        p_din = 8'h01;
        @(posedge mclk);
        #1;
        checks++;
        if (alt_din !== 8'h00) begin
            errors++;
            $display("[TB] FAIL rise E1 alt_din: got %h expected 00", alt_din);
        end
        @(posedge mclk);
        #1;
        checks++;
        if (alt_din !== 8'h01 || irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rise E2: alt_din=%h irq=%b expected 01/0", alt_din, irq);
        end
        bus_read(3'd0, 16'h0001, "PIN at E2");
        @(posedge mclk);
        #1;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rise E3 irq: got %b expected 1", irq);
        end
        bus_read(3'd6, 16'h0001, "PIFG after rise");
        bus_write(3'd6, 8'h00);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL irq clear: got %b expected 0", irq);
        end
    endtask

    task automatic test_fall_pies();
        bus_write(3'd4, 8'h01);
        repeat (3) @(posedge mclk);
        bus_read(3'd6, 16'h0000, "PIFG steady high falling mode");
        @(negedge mclk);
        p_din = 8'h00;
        repeat (2) @(posedge mclk);
        #1;
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fall E2 irq: got %b expected 0", irq);
        end
        @(posedge mclk);
        #1;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL fall E3 irq: got %b expected 1", irq);
        end
        bus_read(3'd6, 16'h0001, "PIFG after fall");
        bus_write(3'd6, 8'h00);
        bus_write(3'd4, 8'h00);
        bus_write(3'd4, 8'h01);
        repeat (2) @(posedge mclk);
        bus_read(3'd6, 16'h0000, "PIFG after PIES toggle");
    endtask

    task automatic test_collision();
        bus_write(3'd5, 8'h04);
        bus_write(3'd6, 8'h01);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("[TB] FAIL masked flag irq: got %b expected 0", irq);
        end
        @(negedge mclk);
        p_din = 8'h04;
        @(posedge mclk);
        @(posedge mclk);
        @(negedge mclk);
        bus_if.per_addr = {BASE[13:3], 3'd6};
        bus_if.per_din  = 16'h0000;
        bus_if.per_we   = 2'b01;
        bus_if.per_en   = 1'b1;
        @(posedge mclk);
        #1;
        bus_if.per_en = 1'b0;
        bus_if.per_we = 2'b00;
        checks++;
        if (irq !== 1'b1) begin
            errors++;
            $display("[TB] FAIL collision irq: got %b expected 1", irq);
        end
        bus_read(3'd6, 16'h0004, "PIFG after collision");
    endtask

    task automatic test_back_to_back();
        bus_write(3'd1, 8'h33);
        bus_write(3'd2, 8'hCC);
        bus_write(3'd7, 8'hFF);
        bus_write(3'd0, 8'hFF);
        bus_read(3'd1, 16'h0033, "b2b POUT");
        bus_read(3'd2, 16'h00CC, "b2b PDIR");
        bus_read(3'd7, 16'h0000, "reserved offset");
        bus_read(3'd0, 16'h0004, "PIN write ignored");
        checks++;
        if (p_dout !== 8'h33 || p_dout_en !== 8'hCC) begin
            errors++;
            $display("[TB] FAIL b2b pads: p_dout=%h p_dout_en=%h expected 33/cc", p_dout, p_dout_en);
        end
    endtask

    initial begin
        test_reset();
        test_gpio_drive();
        test_alt_mux();
        test_rise_irq();
        test_fall_pies();
        test_collision();
        test_back_to_back();
        repeat (2) @(posedge mclk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/msp430_gpio_port.md
# msp430_gpio_port

Parameterised GPIO port controller that configures and sequences a row of `msp430_io_cell` tristate pads from the peripheral bus. It owns direction, output value, and function-select muxing between software GPIO and one alternate peripheral per pin. It synchronises pad inputs and raises edge-triggered interrupt flags. It sits on the peripheral bus beside the other MSP430 peripherals; its pad-side ports connect one-to-one to the io cells.

## Interface
- `WIDTH`, default 8: number of pins, 1..8.
- `BASE_ADDR`, default 14'h0010: word address of the register block; the block decodes `per_addr[13:3]`.
- `mclk` in 1: system clock; all state on rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `per_addr` in 14: peripheral word address.
- `per_din` in 16: write data; only bits [7:0] are used.
- `per_en` in 1: bus access strobe.
- `per_we` in 2: byte write enables; only bit 0 is used; 0 means read.
- `per_dout` out 16: read data; zero when not selected.
- `p_din` in WIDTH: pad values from the io cell `data_in`.
- `p_dout` out WIDTH: pad output values to the io cell `data_out`.
- `p_dout_en` out WIDTH: pad output enables to the io cell `data_out_en`.
- `alt_dout` in WIDTH: alternate-function output value.
- `alt_dout_en` in WIDTH: alternate-function output enable.
- `alt_din` out WIDTH: synchronised pad input to the alternate function.
- `irq` out 1: port interrupt request, level.

## Operation
- The block is selected when `per_en` is 1 and `per_addr[13:3]` equals `BASE_ADDR[13:3]`. The register offset is `per_addr[2:0]`.
- Register map (all WIDTH bits, zero-extended to 16 on read):
  - 0 PIN, read-only: synchronised pad value.
  - 1 POUT.
  - 2 PDIR: 1 = output.
  - 3 PSEL: 1 = alternate function.
  - 4 PIES: 0 = rising edge, 1 = falling edge.
  - 5 PIE: interrupt enable.
  - 6 PIFG: interrupt flag.
  - 7: reserved; reads 0, writes ignored.
- Write: selected and `per_we[0]` is 1. The register at the offset loads `per_din[WIDTH-1:0]`. Writes to PIN are ignored.
- Read: selected and `per_we` is 0. `per_dout` is combinational from the current register contents. At all other times `per_dout` is 0, so it can be OR-combined on the bus.
- Pad mux, combinational per pin i:
  - PSEL[i] = 0: `p_dout[i]` = POUT[i] and `p_dout_en[i]` = PDIR[i].
  - PSEL[i] = 1: `p_dout[i]` = `alt_dout[i]` and `p_dout_en[i]` = `alt_dout_en[i]`.
- Input path: two-flop synchroniser sync1 -> sync2 per pin. PIN and `alt_din` both equal sync2. A third flop, prev, holds the previous sync2.
- Edge detect per pin:
  - rise = sync2 & ~prev; fall = ~sync2 & prev.
  - edge = PIES ? fall : rise.
  - Detection is independent of PDIR, PSEL and PIE.
- PIFG next state = (write to PIFG ? `per_din` : PIFG) | edge. A hardware edge always wins over a simultaneous software clear.
- Changing PIES does not create an edge, because detection compares sync2 against prev, never against PIES.
- `irq` = |(PIFG & PIE), combinational from the registers.

## Timing
- Reset, asynchronous on `reset_n` = 0:
  - All registers, sync1, sync2 and prev clear to 0.
  - Therefore `p_dout_en` = `alt_dout_en` gated by PSEL = 0: all pads hi-Z, `p_dout` = 0, `irq` = 0, `per_dout` = 0, `alt_din` = 0.
- Reset asserted mid-access: the in-flight write is lost.
- Reset release followed by a pad already high: PIN shows 1 two edges later. A rising edge is detected, and PIFG sets 3 edges after release. This is intended behaviour; software clears PIFG after init.
- Register write: the new value takes effect on the clock edge that samples the write strobe. `p_dout`, `p_dout_en` and `irq` change in the same cycle as the register.
- Pad input latency, counting from edge E1 (the first edge at which the new pad level is sampled):
  - E1: sync1 updates.
  - E2: sync2, PIN and `alt_din` update.
  - E3: PIFG sets, and `irq` asserts if PIE is 1.
- Pulses narrower than one `mclk` period may be missed.
- Back-to-back accesses are allowed every cycle. A read in the cycle after a write returns the new value.

## Test plan
- Reset: hold `reset_n` = 0 with `alt_dout_en` = 8'hFF -> `p_dout_en` = 8'h00, `irq` = 0, and every register reads 16'h0000 after release.
- GPIO drive: write PDIR = 8'hA5, then POUT = 8'h0F -> `p_dout_en` = 8'hA5 and `p_dout` = 8'h0F the cycle after each write. Reading offset 1 returns 16'h000F.
- Alternate mux: PSEL = 8'h03, `alt_dout` = 8'h01, `alt_dout_en` = 8'h03, PDIR = 8'h00 -> `p_dout_en` = 8'h03 and `p_dout[1:0]` = 2'b01.
- Rising-edge interrupt: PIE = 8'h01, PIES = 8'h00; drive `p_din[0]` 0 -> 1 before edge E1 -> PIN[0] = 1 at E2, PIFG = 8'h01 and `irq` = 1 at E3. Writing PIFG = 8'h00 clears `irq` the next cycle.
- Falling-edge select and PIES toggle: PIES = 8'h01 with the pin steady high -> no flag. Then a pin 1 -> 0 -> PIFG[0] = 1 at E3. Toggling PIES with the pin steady -> PIFG unchanged.
- Collision: a software write of PIFG = 8'h00 in the same cycle that a hardware edge on pin 2 sets its flag -> PIFG = 8'h04 and `irq` remains 1 (with PIE[2] = 1).
